// File: rtl/fifo_stream_reader.sv
// Consumer side of the FIFO: issues pops, absorbs the one-cycle RAM read latency
// and presents words in order on a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  input  logic [width-1:0] fifoData,
  output logic             read,
  output logic [width-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [15:0]      wordCount,
  output logic             idle
);

  logic [1:0]       occ;
  logic             inflight;
  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic             pop;
  logic [2:0]       committed;

  assign outValid = (occ != 2'd0);
  assign outData  = head;
  assign pop      = outValid & outReady;
  assign idle     = (occ == 2'd0) & ~inflight;

  // Slots already spoken for once this cycle's pop leaves; a new read needs one free.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign read      = enable & ~empty & ~reset & (committed < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      wordCount <= 16'd0;
    end else begin
      inflight <= read;
      if (pop) wordCount <= wordCount + 16'd1;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) head <= fifoData;
          else             tail <= fifoData;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Head leaves while the captured word joins at the tail; occupancy holds.
          if (occ == 2'd2) begin
            head <= tail;
            tail <= fifoData;
          end else begin
            head <= fifoData;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO with one-cycle read
// latency feeds the DUT while a cycle table and a few sequences check the stream.
module tb_fifo_stream_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        empty;
  logic [3:0]  fifo_data = '0;
  logic        read;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_count;
  logic        idle;
  logic        flush;

  logic [3:0] mem [0:65599];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       push;
    logic [3:0] pdata;
    logic       en;
    logic       rdy;
    logic       e_read;
    logic       e_valid;
    logic [3:0] e_data;
    logic       e_idle;
    int         e_cnt;
  } vec_t;

  vec_t v [0:63];
  int   n = 0;

  fifo_stream_reader #(.width(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty),
    .fifoData(fifo_data), .read(read), .outData(out_data), .outValid(out_valid),
    .outReady(out_ready), .wordCount(word_count), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (wr_ptr == rd_ptr);

  // Source FIFO: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (read && !empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [3:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic p, input logic [3:0] pd, input logic en, input logic rdy,
                     input logic er, input logic ev, input logic [3:0] ed, input logic ei,
                     input int ec);
    v[n] = '{p, pd, en, rdy, er, ev, ed, ei, ec};
    n++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!(idle && empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(idle && empty), 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; flush = 1'b0;

    // push pd en rdy | read valid data idle count
    add(1, 4'h3, 0, 1, 0, 0, 4'h0, 1, 0);
    add(1, 4'h7, 0, 1, 0, 0, 4'h0, 1, 0);
    add(1, 4'hA, 0, 1, 0, 0, 4'h0, 1, 0);
    add(0, 4'h0, 1, 1, 1, 0, 4'h0, 1, 0);
    add(0, 4'h0, 1, 1, 1, 0, 4'h0, 0, 0);
    add(0, 4'h0, 1, 1, 1, 1, 4'h3, 0, 0);
    add(0, 4'h0, 1, 1, 0, 1, 4'h7, 0, 1);
    add(0, 4'h0, 1, 1, 0, 1, 4'hA, 0, 2);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 3);
    // backpressure: only two reads, head held, then a gapless drain
    add(1, 4'h1, 0, 0, 0, 0, 4'h0, 1, 3);
    add(1, 4'h2, 0, 0, 0, 0, 4'h0, 1, 3);
    add(1, 4'h3, 0, 0, 0, 0, 4'h0, 1, 3);
    add(1, 4'h4, 0, 0, 0, 0, 4'h0, 1, 3);
    add(0, 4'h0, 1, 0, 1, 0, 4'h0, 1, 3);
    add(0, 4'h0, 1, 0, 1, 0, 4'h0, 0, 3);
    add(0, 4'h0, 1, 0, 0, 1, 4'h1, 0, 3);
    add(0, 4'h0, 1, 0, 0, 1, 4'h1, 0, 3);
    add(0, 4'h0, 1, 0, 0, 1, 4'h1, 0, 3);
    add(0, 4'h0, 1, 1, 1, 1, 4'h1, 0, 3);
    add(0, 4'h0, 1, 1, 1, 1, 4'h2, 0, 4);
    add(0, 4'h0, 1, 1, 0, 1, 4'h3, 0, 5);
    add(0, 4'h0, 1, 1, 0, 1, 4'h4, 0, 6);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 7);
    // single word, FIFO runs dry, later word
    add(1, 4'h5, 0, 1, 0, 0, 4'h0, 1, 7);
    add(0, 4'h0, 1, 1, 1, 0, 4'h0, 1, 7);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 0, 7);
    add(0, 4'h0, 1, 1, 0, 1, 4'h5, 0, 7);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 8);
    add(1, 4'h9, 1, 1, 1, 0, 4'h0, 1, 8);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 0, 8);
    add(0, 4'h0, 1, 1, 0, 1, 4'h9, 0, 8);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0, 1, 9);
    // enable dropped right after a read: in-flight word still delivered
    add(1, 4'h6, 0, 1, 0, 0, 4'h0, 1, 9);
    add(1, 4'h8, 0, 1, 0, 0, 4'h0, 1, 9);
    add(0, 4'h0, 1, 1, 1, 0, 4'h0, 1, 9);
    add(0, 4'h0, 0, 1, 0, 0, 4'h0, 0, 9);
    add(0, 4'h0, 0, 1, 0, 1, 4'h6, 0, 9);
    add(0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 10);
    add(0, 4'h0, 0, 1, 0, 0, 4'h0, 1, 10);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("rst read",  read,       0);
    chk("rst valid", out_valid,  0);
    chk("rst count", word_count, 0);
    chk("rst idle",  idle,       1);
    chk("rst data",  out_data,   0);

    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (v[i].push) push(v[i].pdata);
      enable    = v[i].en;
      out_ready = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d read", i),  read,       v[i].e_read);
      chk($sformatf("v%0d valid", i), out_valid,  v[i].e_valid);
      chk($sformatf("v%0d idle", i),  idle,       v[i].e_idle);
      chk($sformatf("v%0d count", i), word_count, v[i].e_cnt);
      if (v[i].e_valid) chk($sformatf("v%0d data", i), out_data, v[i].e_data);
    end

    // Fill the skid buffer (8 left over plus B), then reset with occ=2.
    @(posedge clk); #1;
    push(4'hB);
    enable = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 push(4'hC);
    @(negedge clk);
    chk("full read",  read,      0);
    chk("full valid", out_valid, 1);
    chk("full data",  out_data,  4'h8);
    #1 reset = 1'b1;
    #1;
    chk("async valid", out_valid,  0);
    chk("async read",  read,       0);
    chk("async idle",  idle,       1);
    chk("async data",  out_data,   0);
    chk("async count", word_count, 0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stale valid %0d", i), out_valid, 0);
      chk($sformatf("stale read %0d", i),  read,      0);
    end

    // Wrap of the transfer counter.
    @(posedge clk); #1;
    for (int i = 0; i < 65535; i++) push(i[3:0]);
    wait_drain("drain 65535", 70000);
    chk("count 65535", word_count, 16'hFFFF);
    @(posedge clk); #1 push(4'hE);
    wait_drain("drain wrap", 20);
    chk("count wrap", word_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
